// File: rtl/alu_flags_pkg.sv
// Shared types for the ALU flags/stack block: condition codes and NZCV bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_flags_pkg;

  // Bit positions of the architectural flags inside the flag register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Condition-code selector, encoded as the 4-bit cond field
  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/alu_flags_stack_if.sv
// Bundle of control inputs and status outputs for the flags register/stack.
// Latency: n/a (wiring only).
// Backpressure: none; push/pop are always accepted, misuse raises err.
interface alu_flags_stack_if
  import alu_flags_pkg::*;
#(
  parameter int NUM_FLAGS   = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [NUM_FLAGS-1:0] flags_in;
  logic [NUM_FLAGS-1:0] upd_mask;
  logic                 push;
  logic                 pop;
  logic                 err_clr;
  cond_e                cond;
  logic [NUM_FLAGS-1:0] flags_out;
  logic                 cond_true;
  logic [DW-1:0]        depth;
  logic                 full;
  logic                 empty;
  logic                 err;

  modport master (
    output flags_in, upd_mask, push, pop, err_clr, cond,
    input  flags_out, cond_true, depth, full, empty, err
  );

  modport slave (
    input  flags_in, upd_mask, push, pop, err_clr, cond,
    output flags_out, cond_true, depth, full, empty, err
  );

endinterface

// File: rtl/alu_cond_eval.sv
// Evaluates a 4-bit condition code against an NZCV flag nibble.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module alu_cond_eval
  import alu_flags_pkg::*;
(
  input  logic [3:0] nzcv,
  input  cond_e      cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // Decode the selected condition from the individual flags
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = ~n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = ~v;
      COND_HI: cond_true = c & ~z;
      COND_LS: cond_true = ~c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = ~z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flags_stack.sv
// Flag register with per-bit update mask, LIFO save/restore stack and condition evaluation.
// Latency: flags/depth/err update on the next rising edge; cond_true, full, empty are same-cycle.
// Backpressure: none; push on full or pop on empty is dropped and sets sticky err.
module alu_flags_stack
  import alu_flags_pkg::*;
#(
  parameter int NUM_FLAGS   = 4,
  parameter int STACK_DEPTH = 4
)
(
  input logic              clk,
  input logic              rst,
  alu_flags_stack_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [NUM_FLAGS-1:0] flags_q, flags_d, masked, top_val;
  logic [NUM_FLAGS-1:0] stack_mem [STACK_DEPTH];
  logic [DW-1:0]        depth_q, depth_d, top_dep;
  logic [AW-1:0]        top_idx, push_idx;
  logic                 full_w, empty_w;
  logic                 do_push, do_pop, do_swap, err_ev;
  logic                 err_q, err_d;

  assign full_w   = (depth_q == DW'(STACK_DEPTH));
  assign empty_w  = (depth_q == '0);
  assign top_dep  = depth_q - DW'(1);
  assign top_idx  = top_dep[AW-1:0];
  assign push_idx = depth_q[AW-1:0];
  assign top_val  = stack_mem[top_idx];
  assign masked   = (flags_q & ~bus.upd_mask) | (bus.flags_in & bus.upd_mask);

  // Classify this cycle's stack request; illegal requests fall back to a plain mask update
  always_comb begin
    do_push = bus.push & ~bus.pop & ~full_w;
    do_pop  = bus.pop & ~bus.push & ~empty_w;
    do_swap = bus.push & bus.pop & ~empty_w;
    err_ev  = (bus.push & ~bus.pop & full_w) |
              (bus.pop & ~empty_w ? 1'b0 : bus.pop);
  end

  // Next flags, depth and sticky error; a new error wins over err_clr
  always_comb begin
    flags_d = masked;
    depth_d = depth_q;
    err_d   = err_q;
    if (do_pop || do_swap) flags_d = top_val;
    if (do_push) depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);
    if (err_ev) err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  // Architectural state with synchronous active-low reset that discards saved entries
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset: an entry is only read after it has been pushed
  always_ff @(posedge clk) begin
    if (rst) begin
      if (do_push) stack_mem[push_idx] <= flags_q;
      else if (do_swap) stack_mem[top_idx] <= flags_q;
    end
  end

  alu_cond_eval u_cond (
    .nzcv      (flags_q[3:0]),
    .cond      (bus.cond),
    .cond_true (bus.cond_true)
  );

  assign bus.flags_out = flags_q;
  assign bus.depth     = depth_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.err       = err_q;

endmodule

// File: doc/alu_flags_stack.md
ALU_FLAGS_STACK -- requirements
Module: alu_flags_stack

Interface
REQ-001 SHALL provide parameter NUM_FLAGS, default 4, flag register width (>=4; bits [3:0] = N,Z,C,V; higher bits user flags, no condition semantics).
REQ-002 SHALL provide parameter STACK_DEPTH, default 4, number of flag-save entries (>=2).
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port flags_in  input  NUM_FLAGS  new flag values from ALU.
REQ-006 SHALL provide port upd_mask  input  NUM_FLAGS  per-flag write enable.
REQ-007 SHALL provide port push  input  1  save current flags to stack.
REQ-008 SHALL provide port pop  input  1  restore flags from stack top.
REQ-009 SHALL provide port err_clr  input  1  clear sticky error.
REQ-010 SHALL provide port cond  input  4  condition-code select.
REQ-011 SHALL provide port flags_out  output  NUM_FLAGS  registered current flags.
REQ-012 SHALL provide port cond_true  output  1  evaluation of cond on flags_out.
REQ-013 SHALL provide port depth  output  $clog2(STACK_DEPTH+1)  occupied entries.
REQ-014 SHALL provide ports full, empty  output  1 each  depth==STACK_DEPTH, depth==0.
REQ-015 SHALL provide port err  output  1  sticky overflow/underflow indicator.

Function
REQ-016 With push=pop=0, flags_out[i] SHALL take flags_in[i] next edge where upd_mask[i]=1, else hold.
REQ-017 push=1, pop=0, not full: current flags_out (pre-update) SHALL be written at entry depth, depth+1; mask update applies same edge.
REQ-018 push=1, pop=0, full: stack and depth SHALL be unchanged, err set; mask update still applies.
REQ-019 pop=1, push=0, not empty: flags_out SHALL load top entry, depth-1; upd_mask ignored that cycle.
REQ-020 pop=1, push=0, empty: depth unchanged, err set, mask update applies normally.
REQ-021 push=pop=1, not empty: SHALL swap flags_out with top entry, depth unchanged, upd_mask ignored.
REQ-022 push=pop=1, empty: SHALL set err, mask update applies, depth stays 0.
REQ-023 cond_true SHALL be combinational from flags_out/cond, zero latency: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-024 err SHALL stay 1 until err_clr; err_clr clears next edge; new error in same cycle as err_clr SHALL leave err=1 (set wins).
REQ-025 full, empty SHALL derive from registered depth, no extra latency.

Reset
REQ-026 rst=0 at an edge SHALL force flags_out=0, depth=0, empty=1, full=0, err=0, overriding push/pop/mask that cycle.
REQ-027 Stack storage SHALL not require reset; contents unobservable until pushed.
REQ-028 Reset mid-sequence SHALL discard all saved entries.

Structure
REQ-029 Package alu_flags_pkg SHALL hold cond_e enum (16 codes above) and FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0 index constants.
REQ-030 Condition evaluation SHALL be a sub-module alu_cond_eval (purely combinational, 4-bit NZCV + cond in, 1-bit out).

Verification (NUM_FLAGS=4, STACK_DEPTH=4)
REQ-031 Reset, then flags_in=4'b1010, upd_mask=4'b1111 -> flags_out=4'b1010 next edge; then mask=4'b0100, flags_in=4'b0101 -> flags_out=4'b1110.
REQ-032 flags_out=4'b1000: push, then flags_in=4'b0100 mask=4'hF, then pop -> flags_out=4'b1000, depth 1->0, empty=1.
REQ-033 Five consecutive pushes -> depth=4, full=1 after fourth, err=1 after fifth; err_clr -> err=0 next edge.
REQ-034 Pop when empty with mask=4'hF, flags_in=4'b0011 -> err=1, flags_out=4'b0011, depth=0.
REQ-035 Stack top=4'b0001, flags_out=4'b1000, push=pop=1 -> flags_out=4'b0001, top=4'b1000, depth unchanged.
REQ-036 Sweep cond 0..15 over all 16 NZCV values against table REQ-023 (e.g. NZCV=4'b1001, cond=10 GE -> 1, cond=12 GT -> 1); rst=0 during push -> depth=0.
